alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 111 +++++++++++
 tb/tb_alu_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// ALU sequencing controller: accepts an operation request and launches the ALU.
// It waits for the ALU to report ready, with a timeout, then pulses done.
// Outputs are decoded from the state and forced low while reset is asserted.
module alu_ctrl #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           ALU_ready,
    output logic           ALU_start,
    output logic [OPW-1:0] ALU_op,
    output logic           flags_we,
    output logic           busy,
    output logic           done,
    output logic           error
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    // Counter value seen in the final permitted WAIT cycle
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q;
    logic [OPW-1:0]   op_q;
    logic             error_q;
    logic             wait_expired;

    // Ready takes priority, so expiry only counts when ALU_ready is low
    assign wait_expired = (state_q == StWait) && !ALU_ready && (cnt_q == CntLast);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (ALU_ready || wait_expired) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Opcode capture, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            op_q    <= '0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= opcode;
                        error_q <= 1'b0;
                    end
                end
                StIssue: cnt_q <= 8'd0;
                StWait: begin
                    if (wait_expired) begin
                        error_q <= 1'b1;
                    end else if (!ALU_ready) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; strobes are suppressed during reset so an aborted op leaves no trace
    always_comb begin
        ALU_start = 1'b0;
        flags_we  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            case (state_q)
                StIssue: begin
                    ALU_start = 1'b1;
                    busy      = 1'b1;
                end
                StWait: begin
                    flags_we = ALU_ready;
                    busy     = 1'b1;
                end
                StDone: begin
                    done = 1'b1;
                    busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ALU_op = op_q;
    assign error  = error_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: inputs change on the falling edge and outputs
// are checked 1 ns later, so each check sees the state of the current cycle.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] opcode;
    logic       ALU_ready;
    logic       ALU_start;
    logic [3:0] ALU_op;
    logic       flags_we;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    alu_ctrl #(.OPW(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .ALU_ready (ALU_ready),
        .ALU_start (ALU_start),
        .ALU_op    (ALU_op),
        .flags_we  (flags_we),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for the next cycle, then let combinational outputs settle
    task automatic drive(input logic rst, input logic st, input logic [3:0] op,
                         input logic rdy);
        @(negedge clk);
        reset     = rst;
        start     = st;
        opcode    = op;
        ALU_ready = rdy;
        #1;
    endtask

    task automatic expect_o(input string tag, input logic as, input logic fw,
                            input logic bz, input logic dn, input logic er);
        check({tag, ".ALU_start"}, 32'(ALU_start), 32'(as));
        check({tag, ".flags_we"},  32'(flags_we),  32'(fw));
        check({tag, ".busy"},      32'(busy),      32'(bz));
        check({tag, ".done"},      32'(done),      32'(dn));
        check({tag, ".error"},     32'(error),     32'(er));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 4'h0; ALU_ready = 1'b0;

        // Reset held across three rising edges
        drive(1, 0, 4'h0, 0);
        drive(1, 0, 4'h0, 1);
        expect_o("rst", 0, 0, 0, 0, 0);
        check("rst.ALU_op", 32'(ALU_op), 32'h0);

        // Basic op: start with 0011, ready two cycles later
        drive(0, 1, 4'h3, 0);
        expect_o("b.idle", 0, 0, 0, 0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("b.issue", 1, 0, 1, 0, 0);
        check("b.issue.op", 32'(ALU_op), 32'h3);
        drive(0, 0, 4'h0, 1);
        expect_o("b.wait", 0, 1, 1, 0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("b.done", 0, 0, 1, 1, 0);
        check("b.done.op", 32'(ALU_op), 32'h3);
        drive(0, 0, 4'h0, 0);
        expect_o("b.after", 0, 0, 0, 0, 0);

        // Timeout: ready never arrives, 15 WAIT cycles then DONE with error
        drive(0, 1, 4'h5, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("t.issue", 1, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 4'h0, 0);
            expect_o($sformatf("t.wait%0d", i), 0, 0, 1, 0, 0);
        end
        drive(0, 0, 4'h0, 0);
        expect_o("t.done", 0, 0, 1, 1, 1);
        drive(0, 0, 4'h0, 0);
        expect_o("t.idle_hold", 0, 0, 0, 0, 1);

        // Next start clears error; ready in the 15th WAIT cycle wins over timeout
        drive(0, 1, 4'hA, 0);
        expect_o("l.idle", 0, 0, 0, 0, 1);
        drive(0, 0, 4'h0, 0);
        expect_o("l.issue", 1, 0, 1, 0, 0);
        check("l.op", 32'(ALU_op), 32'hA);
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 4'h0, 0);
            expect_o($sformatf("l.wait%0d", i), 0, 0, 1, 0, 0);
        end
        drive(0, 0, 4'h0, 1);
        expect_o("l.wait14", 0, 1, 1, 0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("l.done", 0, 0, 1, 1, 0);
        drive(0, 0, 4'h0, 0);

        // start and opcode changes while busy are ignored and not queued
        drive(0, 1, 4'h2, 0);
        drive(0, 1, 4'hF, 0);
        expect_o("q.issue", 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'hF, 0);
            expect_o($sformatf("q.wait%0d", i), 0, 0, 1, 0, 0);
            check($sformatf("q.op%0d", i), 32'(ALU_op), 32'h2);
        end
        drive(0, 1, 4'hF, 1);
        expect_o("q.ready", 0, 1, 1, 0, 0);
        drive(0, 1, 4'hF, 0);
        expect_o("q.done", 0, 0, 1, 1, 0);
        check("q.done.op", 32'(ALU_op), 32'h2);
        drive(0, 0, 4'h0, 0);
        expect_o("q.idle", 0, 0, 0, 0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("q.noqueue", 0, 0, 0, 0, 0);

        // Reset during WAIT with ready high aborts silently
        drive(0, 1, 4'h7, 0);
        drive(0, 0, 4'h0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("r.wait", 0, 0, 1, 0, 0);
        drive(1, 0, 4'h0, 1);
        expect_o("r.inrst", 0, 0, 0, 0, 0);
        drive(0, 0, 4'h0, 1);
        expect_o("r.after", 0, 0, 0, 0, 0);
        check("r.op", 32'(ALU_op), 32'h0);

        // ALU_ready in IDLE has no effect
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 4'h0, 1);
            expect_o($sformatf("i.rdy%0d", i), 0, 0, 0, 0, 0);
        end

        // start held through reset is taken on the first edge after release
        drive(1, 1, 4'h9, 0);
        drive(1, 1, 4'h9, 0);
        expect_o("s.inrst", 0, 0, 0, 0, 0);
        drive(0, 1, 4'h9, 0);
        expect_o("s.idle", 0, 0, 0, 0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("s.issue", 1, 0, 1, 0, 0);
        check("s.op", 32'(ALU_op), 32'h9);
        drive(0, 0, 4'h0, 1);
        expect_o("s.wait", 0, 1, 1, 0, 0);
        drive(0, 0, 4'h0, 0);
        expect_o("s.done", 0, 0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
